// File: rtl/time_load_arbiter.sv
// Round-robin arbiter sharing the watch_time load port (set_time/bin_time) between
// N_REQ requesters; a load never starts in a cycle that follows a sampled 1 Hz tick.
module time_load_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned TIME_W   = 48,
    parameter int unsigned HOLD_CYC = 2,
    localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk1sec,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*TIME_W-1:0]   req_time,
    output logic [N_REQ-1:0]          ack,
    output logic                      set_time,
    output logic [TIME_W-1:0]         bin_time,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy
);

    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_owner;
    logic [TIME_W-1:0]  r_bin;
    logic               r_set;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [TIME_W-1:0]  w_bin_nxt;
    logic               w_set_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic               w_busy_nxt;

    logic [IDX_W-1:0]   w_win;
    logic               w_any;
    logic [SUM_W-1:0]   w_sum;

    // Scan downward so the index closest to r_ptr (in rotation order) wins last.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_sum = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            w_sum = SUM_W'(r_ptr) + SUM_W'(i);
            if (w_sum >= SUM_W'(N_REQ)) begin
                w_sum = w_sum - SUM_W'(N_REQ);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                w_win = w_sum[IDX_W-1:0];
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_bin_nxt   = r_bin;
        w_set_nxt   = 1'b0;
        w_ack_nxt   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_win;
                    w_bin_nxt   = req_time[int'(w_win)*TIME_W +: TIME_W];
                end
            end
            ST_GRANT: begin
                if (!req[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end else if (!clk1sec) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                    w_set_nxt   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (r_cnt == '0) begin
                    w_state_nxt        = ST_ACK;
                    w_ack_nxt[r_owner] = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_set_nxt = 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_owner <= '0;
            r_bin   <= '0;
            r_set   <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_bin   <= w_bin_nxt;
            r_set   <= w_set_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign ack      = r_ack;
    assign set_time = r_set;
    assign bin_time = r_bin;
    assign owner    = r_owner;
    assign busy     = r_busy;

endmodule
